// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive front end for the host command link.
// Deserialises 8-bit frames (start, 8 data LSB first, parity, stop) from the
// RX pin and presents each byte to the command decoder over a Receive/Received
// request/acknowledge handshake.
//
// Optional build feature:
//   RX_GLITCH_FILTER_EN - when defined, every START/DATA/PARITY/STOP sample is
//   the 2-of-3 majority of the synchronised line at the cycles just before, at
//   and just after the mid-bit point, rejecting single-cycle glitches. Sample
//   timing is the same in both builds.
module uart_rx_frame #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 19_200,
    parameter int PARITY_ODD = 1
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Sin,
    input  logic       Received,
    output logic       Receive,
    output logic [7:0] Dout,
    output logic       parityErr,
    output logic       frameErr
);

    localparam int BIT_CNT = CLK_FREQ / BAUD_RATE;
    localparam int HALF    = BIT_CNT / 2;
    localparam int CW      = $clog2(BIT_CNT);

    // Terminal counts: start validated at half a bit, every later bit one full bit on.
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_ACK    = 3'd5,
        S_BREAK  = 3'd6
    } state_t;

    // True when data plus received parity bit disagree with the configured sense.
    function automatic logic parity_err(input logic [7:0] data, input logic par);
        return ((^{data, par}) != PAR_ODD) ? 1'b1 : 1'b0;
    endfunction

    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            perr_q;
    logic            receive_q;
    logic [7:0]      dout_q;
    logic            parity_err_q;
    logic            frame_err_q;

    logic            sync1_q;
    logic            sync2_q;
    logic            bit_s;

`ifdef RX_GLITCH_FILTER_EN
    logic            sync3_q;

    // Synchroniser plus one cycle of history for the majority vote; idles high.
    always_ff @(posedge clk) begin
        if (Reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= Sin;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // sync2_q is the synced line at the sample cycle, sync3_q the cycle before,
    // and sync1_q is the value sync2_q takes on the next cycle. Voting on these
    // centres the window on the sample point without moving it. A metastable
    // sync1_q only matters when the other two disagree, i.e. at a real edge.
    assign bit_s = maj3(sync3_q, sync2_q, sync1_q);
`else
    // Two-flop synchroniser for the asynchronous RX pin; idles high.
    always_ff @(posedge clk) begin
        if (Reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= Sin;
            sync2_q <= sync1_q;
        end
    end

    assign bit_s = sync2_q;
`endif

    // Receive FSM: bit timing, deserialisation, parity/stop checks and handshake.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            perr_q       <= 1'b0;
            receive_q    <= 1'b0;
            dout_q       <= 8'h00;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            // frameErr is a single-cycle pulse unless re-asserted below.
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Start detection uses the plain synced value, even when filtered.
                    if (!sync2_q) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        bit_q <= 3'd0;
                        if (!bit_s) begin
                            state_q <= S_DATA;
                        end else begin
                            // Line went back high before mid start bit: false start.
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {bit_s, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= S_PARITY;
                            bit_q   <= 3'd0;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_PARITY: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        perr_q  <= parity_err(shift_q, bit_s);
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (bit_s) begin
                            // Good stop bit: publish the byte and raise the request.
                            dout_q       <= shift_q;
                            parity_err_q <= perr_q;
                            receive_q    <= 1'b1;
                            state_q      <= S_ACK;
                        end else begin
                            // Stop bit low: discard byte, keep previous Dout/parityErr.
                            frame_err_q  <= 1'b1;
                            state_q      <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_ACK: begin
                    // Line activity is ignored until the consumer acknowledges.
                    if (Received) begin
                        receive_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        receive_q <= 1'b1;
                    end
                end
                S_BREAK: begin
                    // No start detection until the line has returned to idle.
                    if (sync2_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_BREAK;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    cnt_q     <= '0;
                    bit_q     <= 3'd0;
                    receive_q <= 1'b0;
                end
            endcase
        end
    end

    assign Receive   = receive_q;
    assign Dout      = dout_q;
    assign parityErr = parity_err_q;
    assign frameErr  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame at BIT_CNT = 10, odd parity.
module tb_uart_rx_frame;

    localparam int BITC = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin;
    logic       ack_auto;
    logic       ack_man;
    logic       receive;
    logic [7:0] dout;
    logic       perr;
    logic       ferr;
    wire        received = ack_auto ? receive : ack_man;

    always #5 clk = ~clk;

    uart_rx_frame #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (100_000),
        .PARITY_ODD(1)
    ) dut (
        .clk      (clk),
        .Reset    (rst),
        .Sin      (sin),
        .Received (received),
        .Receive  (receive),
        .Dout     (dout),
        .parityErr(perr),
        .frameErr (ferr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Passive monitor state
    int         rx_count    = 0;
    int         fe_count    = 0;
    int         recv_len    = 0;
    int         last_len    = 0;
    int         fe_len      = 0;
    int         fe_last_len = 0;
    int         viol        = 0;
    logic [7:0] last_dout   = 8'h00;
    logic       last_perr   = 1'b0;
    logic       prev_recv   = 1'b0;
    logic       prev_ferr   = 1'b0;
    logic       prev_rst    = 1'b1;
    logic       mon_en      = 1'b0;
    logic [7:0] prev_dout   = 8'h00;
    logic       prev_perr   = 1'b0;
    logic [8:0] cap_q[$];

    // Records request pulses, frame-error pulses and any unexpected output change.
    always @(negedge clk) begin
        prev_recv <= receive;
        prev_ferr <= ferr;
        prev_rst  <= rst;
        prev_dout <= dout;
        prev_perr <= perr;
        if (receive && !prev_recv) begin
            rx_count  <= rx_count + 1;
            last_dout <= dout;
            last_perr <= perr;
            cap_q.push_back({perr, dout});
        end
        if (receive) recv_len <= recv_len + 1;
        else begin
            if (prev_recv) last_len <= recv_len;
            recv_len <= 0;
        end
        if (ferr && !prev_ferr) fe_count <= fe_count + 1;
        if (ferr) fe_len <= fe_len + 1;
        else begin
            if (prev_ferr) fe_last_len <= fe_len;
            fe_len <= 0;
        end
        if (mon_en && !prev_rst && !(receive && !prev_recv) &&
            ((dout !== prev_dout) || (perr !== prev_perr)))
            viol <= viol + 1;
    end

    // Reference model: parity bit that makes the total count of ones odd.
    function automatic logic good_par(input logic [7:0] b);
        return (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
    endfunction

    // Reference model: parity error when the ones in data+parity are not odd.
    function automatic logic exp_perr(input logic [7:0] b, input logic p);
        return (($countones({b, p}) % 2) != 1) ? 1'b1 : 1'b0;
    endfunction

    task automatic drive_line(input logic v, input int n);
        sin = v;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // glitch_bit >= 0 inverts the line for one cycle in the middle of that data bit.
    task automatic send_frame(input logic [7:0] b, input logic p, input logic stop,
                              input int glitch_bit);
        drive_line(1'b0, BITC);
        for (int i = 0; i < 8; i++) begin
            if (glitch_bit == i) begin
                drive_line(b[i], 5);
                drive_line(~b[i], 1);
                drive_line(b[i], 4);
            end else begin
                drive_line(b[i], BITC);
            end
        end
        drive_line(p, BITC);
        drive_line(stop, BITC);
        sin = 1'b1;
    endtask

    task automatic test_reset;
        sin = 1'b1; ack_auto = 1'b1; ack_man = 1'b0; rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (receive !== 1'b0) begin n_fail++; $display("FAIL reset_receive: got %b expected 0", receive); end
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", dout); end
        n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL reset_parityErr: got %b expected 0", perr); end
        n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_frameErr: got %b expected 0", ferr); end
        mon_en = 1'b1;
    endtask

    task automatic test_good_frame;
        int rc0 = rx_count;
        int fe0 = fe_count;
        logic [7:0] b = 8'h30;
        logic p = good_par(b);
        send_frame(b, p, 1'b1, -1);
        drive_line(1'b1, 5);
        @(negedge clk);
        n_checks++; if (rx_count !== rc0 + 1) begin n_fail++; $display("FAIL good_count: got %0d expected %0d", rx_count, rc0 + 1); end
        n_checks++; if (last_dout !== b) begin n_fail++; $display("FAIL good_dout: got %h expected %h", last_dout, b); end
        n_checks++; if (last_perr !== exp_perr(b, p)) begin n_fail++; $display("FAIL good_perr: got %b expected %b", last_perr, exp_perr(b, p)); end
        n_checks++; if (last_len !== 1) begin n_fail++; $display("FAIL good_pulse_len: got %0d expected 1", last_len); end
        n_checks++; if (fe_count !== fe0) begin n_fail++; $display("FAIL good_no_frameErr: got %0d expected %0d", fe_count, fe0); end
    endtask

    task automatic test_bad_parity;
        int rc0 = rx_count;
        logic [7:0] b = 8'h31;
        logic p = ~good_par(b);   // deliberately the wrong parity bit
        send_frame(b, p, 1'b1, -1);
        drive_line(1'b1, 5);
        @(negedge clk);
        n_checks++; if (rx_count !== rc0 + 1) begin n_fail++; $display("FAIL badpar_count: got %0d expected %0d", rx_count, rc0 + 1); end
        n_checks++; if (last_dout !== b) begin n_fail++; $display("FAIL badpar_dout: got %h expected %h", last_dout, b); end
        n_checks++; if (last_perr !== exp_perr(b, p)) begin n_fail++; $display("FAIL badpar_perr: got %b expected %b", last_perr, exp_perr(b, p)); end
    endtask

    task automatic test_frame_error;
        int rc0 = rx_count;
        int fe0 = fe_count;
        logic [7:0] b = 8'h33;
        send_frame(8'h32, good_par(8'h32), 1'b0, -1);
        drive_line(1'b0, 40);
        drive_line(1'b1, 5);
        @(negedge clk);
        n_checks++; if (fe_count !== fe0 + 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected %0d", fe_count, fe0 + 1); end
        n_checks++; if (fe_last_len !== 1) begin n_fail++; $display("FAIL ferr_pulse_len: got %0d expected 1", fe_last_len); end
        n_checks++; if (rx_count !== rc0) begin n_fail++; $display("FAIL ferr_no_receive: got %0d expected %0d", rx_count, rc0); end
        n_checks++; if (dout !== 8'h31) begin n_fail++; $display("FAIL ferr_dout_kept: got %h expected 31", dout); end
        n_checks++; if (perr !== exp_perr(8'h31, ~good_par(8'h31))) begin n_fail++; $display("FAIL ferr_perr_kept: got %b expected 1", perr); end
        send_frame(b, good_par(b), 1'b1, -1);
        drive_line(1'b1, 5);
        @(negedge clk);
        n_checks++; if (rx_count !== rc0 + 1) begin n_fail++; $display("FAIL after_break_count: got %0d expected %0d", rx_count, rc0 + 1); end
        n_checks++; if (last_dout !== b) begin n_fail++; $display("FAIL after_break_dout: got %h expected %h", last_dout, b); end
        n_checks++; if (last_perr !== 1'b0) begin n_fail++; $display("FAIL after_break_perr: got %b expected 0", last_perr); end
    endtask

    task automatic test_false_start;
        int rc0 = rx_count;
        int fe0 = fe_count;
        logic [7:0] b = 8'h34;
        drive_line(1'b0, 3);
        drive_line(1'b1, 20);
        @(negedge clk);
        n_checks++; if (rx_count !== rc0) begin n_fail++; $display("FAIL false_start_receive: got %0d expected %0d", rx_count, rc0); end
        n_checks++; if (fe_count !== fe0) begin n_fail++; $display("FAIL false_start_frameErr: got %0d expected %0d", fe_count, fe0); end
        send_frame(b, good_par(b), 1'b1, -1);
        drive_line(1'b1, 5);
        @(negedge clk);
        n_checks++; if (last_dout !== b) begin n_fail++; $display("FAIL false_start_next_dout: got %h expected %h", last_dout, b); end
    endtask

    task automatic test_stall;
        int rc0 = rx_count;
        int stable = 0;
        ack_auto = 1'b0; ack_man = 1'b0;
        send_frame(8'h35, good_par(8'h35), 1'b1, -1);
        drive_line(1'b1, 2);
        @(negedge clk);
        for (int i = 0; i < 100 && receive !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            if (receive === 1'b1 && dout === 8'h35) stable++;
            @(negedge clk);
        end
        n_checks++; if (stable !== 50) begin n_fail++; $display("FAIL stall_hold: got %0d stable cycles expected 50", stable); end
        @(posedge clk);
        #1 ack_man = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (receive !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b expected 0", receive); end
        ack_man = 1'b0; ack_auto = 1'b1;
        n_checks++; if (rx_count !== rc0 + 1) begin n_fail++; $display("FAIL stall_count: got %0d expected %0d", rx_count, rc0 + 1); end
        send_frame(8'h36, good_par(8'h36), 1'b1, -1);
        drive_line(1'b1, 5);
        @(negedge clk);
        n_checks++; if (last_dout !== 8'h36) begin n_fail++; $display("FAIL stall_next_dout: got %h expected 36", last_dout); end
    endtask

    task automatic test_reset_midframe;
        int rc0 = rx_count;
        logic [7:0] b = 8'hF5;   // bits 4..7, parity and stop all high
        drive_line(1'b0, BITC);
        for (int i = 0; i < 4; i++) drive_line(b[i], BITC);
        drive_line(b[4], 5);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (receive !== 1'b0) begin n_fail++; $display("FAIL midrst_receive: got %b expected 0", receive); end
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL midrst_dout: got %h expected 00", dout); end
        n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL midrst_perr: got %b expected 0", perr); end
        n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL midrst_ferr: got %b expected 0", ferr); end
        drive_line(1'b1, 4 + 5 * BITC);
        @(negedge clk);
        n_checks++; if (rx_count !== rc0) begin n_fail++; $display("FAIL midrst_no_receive: got %0d expected %0d", rx_count, rc0); end
        send_frame(8'h36, good_par(8'h36), 1'b1, -1);
        drive_line(1'b1, 5);
        @(negedge clk);
        n_checks++; if (last_dout !== 8'h36) begin n_fail++; $display("FAIL midrst_next_dout: got %h expected 36", last_dout); end
    endtask

    task automatic test_back_to_back;
        cap_q.delete();
        send_frame(8'h40, good_par(8'h40), 1'b1, -1);
        send_frame(8'hBF, ~good_par(8'hBF), 1'b1, -1);
        drive_line(1'b1, 5);
        @(negedge clk);
        n_checks++; if (cap_q.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", cap_q.size()); end
        else begin
            n_checks++; if (cap_q[0] !== {1'b0, 8'h40}) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", cap_q[0], {1'b0, 8'h40}); end
            n_checks++; if (cap_q[1] !== {1'b1, 8'hBF}) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", cap_q[1], {1'b1, 8'hBF}); end
        end
    endtask

    task automatic test_random;
        logic [8:0] exp_q[$];
        logic [7:0] b;
        logic       p;
        cap_q.delete();
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom_range(0, 255));
            p = good_par(b) ^ (($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
            exp_q.push_back({exp_perr(b, p), b});
            send_frame(b, p, 1'b1, -1);
            drive_line(1'b1, $urandom_range(0, 15));
        end
        drive_line(1'b1, 5);
        @(negedge clk);
        n_checks++; if (cap_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", cap_q.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (cap_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_frame%0d: got perr/dout %h expected %h", i, cap_q[i], exp_q[i]);
                end
            end
        end
    endtask

`ifdef RX_GLITCH_FILTER_EN
    task automatic test_glitch;
        int rc0 = rx_count;
        send_frame(8'h30, good_par(8'h30), 1'b1, 3);
        drive_line(1'b1, 5);
        @(negedge clk);
        n_checks++; if (rx_count !== rc0 + 1) begin n_fail++; $display("FAIL glitch_count: got %0d expected %0d", rx_count, rc0 + 1); end
        n_checks++; if (last_dout !== 8'h30) begin n_fail++; $display("FAIL glitch_dout: got %h expected 30", last_dout); end
        n_checks++; if (last_perr !== 1'b0) begin n_fail++; $display("FAIL glitch_perr: got %b expected 0", last_perr); end
    endtask
`endif

    task automatic test_stability;
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL output_stability: got %0d unexpected changes expected 0", viol); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_frame_error();
        test_false_start();
        test_stall();
        test_reset_midframe();
        test_back_to_back();
        test_random();
`ifdef RX_GLITCH_FILTER_EN
        test_glitch();
`endif
        test_stability();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
